// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter
//   Round-robin arbiter in front of one shared parallel-in/parallel-out register.
//   Each requester holds req[i] and a stable data word until it sees its ack
//   pulse. The arbiter grants one requester at a time, loads that requester's
//   word into the register and records which requester loaded it.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   req         per-requester write request (level, held until ack)
//   din_flat    requester i data at [i*WIDTH +: WIDTH]
//   gnt         registered one-hot grant, zero when idle
//   ack         one-cycle pulse to the requester whose word was loaded
//   dout        shared register contents
//   dout_valid  high once any word has been loaded since reset
//   owner       index of the requester that last loaded dout
//   busy        high while a grant is being serviced (GRANT or ACK)
//   state_dbg   current FSM state (0=IDLE, 1=GRANT, 2=ACK)
//
// Handshake: a requester raises req[i] with its word on din_flat and keeps both
// stable until ack[i] is seen. Dropping req[i] while gnt[i] is high and before
// ack aborts that grant without a load. One load takes three cycles.
module pipo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din_flat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;      // first index scanned on the next arbitration
  logic [IDXW-1:0] winner;   // requester currently granted

  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic [IDXW-1:0] cand;

  // Scan from ptr upward (mod NREQ). Walking offsets high-to-low lets the
  // lowest offset with a pending request overwrite the others, so it wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      cand = IDXW'((int'(ptr) + o) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gnt        <= '0;
      ack        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      owner      <= '0;
      ptr        <= '0;
      winner     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack <= '0;
          if (pick_valid) begin
            winner <= pick_idx;
            gnt    <= NREQ'(1) << pick_idx;
            busy   <= 1'b1;
            state  <= S_GRANT;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        S_GRANT: begin
          if (req[winner]) begin
            dout       <= din_flat[winner*WIDTH +: WIDTH];
            owner      <= winner;
            dout_valid <= 1'b1;
            ack        <= NREQ'(1) << winner;
            // The winner moves to lowest priority for the next scan.
            ptr        <= (winner == IDXW'(NREQ - 1)) ? '0 : winner + 1'b1;
            state      <= S_ACK;
          end else begin
            // Requester withdrew: drop the grant, keep ptr so the scan repeats.
            gnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ACK: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Directed testbench for pipo_write_arbiter: reset values, single-requester
// latency, round-robin order, fairness with a held request, abort, and reset
// in the middle of a grant. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_pipo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDXW  = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din_flat;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;
  logic [IDXW-1:0]       owner;
  logic                  busy;
  logic [1:0]            state_dbg;

  always #5 clk = ~clk;

  pipo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din_flat   (din_flat),
    .gnt        (gnt),
    .ack        (ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .owner      (owner),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One active edge, then back to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [WIDTH-1:0] v);
    din_flat[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Full load of requester idx: grant after first edge, load/ack after second,
  // requester drops req during ack, idle after third edge.
  task automatic expect_load(input string tag, input int idx, input logic [WIDTH-1:0] d,
                             input bit drop);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    step();
    check({tag, "_gnt"},  32'(gnt), 32'(oh));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    step();
    check({tag, "_ack"},   32'(ack), 32'(oh));
    check({tag, "_dout"},  32'(dout), 32'(d));
    check({tag, "_owner"}, 32'(owner), 32'(idx));
    if (drop) req[idx] = 1'b0;
    step();
    check({tag, "_ack_low"},  32'(ack), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] held_dout;
    reset    = 1'b1;
    req      = '0;
    din_flat = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1) reset values
    check("rst_dout",  32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // idle with no request stays idle
    step();
    check("idle_gnt", 32'(gnt), 32'd0);

    // 2) single requester 2 with 0xA
    set_din(2, 4'hA);
    req = 4'b0100;
    step();
    check("single_gnt",   32'(gnt), 32'h4);
    check("single_ack0",  32'(ack), 32'd0);
    check("single_valid0", 32'(dout_valid), 32'd0);
    step();
    check("single_dout",  32'(dout), 32'hA);
    check("single_owner", 32'(owner), 32'd2);
    check("single_ack",   32'(ack), 32'h4);
    check("single_valid", 32'(dout_valid), 32'd1);
    check("single_ack_in_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    check("single_busy_low", 32'(busy), 32'd0);
    check("single_ack_low",  32'(ack), 32'd0);
    check("single_gnt_low",  32'(gnt), 32'd0);
    step();
    check("single_hold_dout", 32'(dout), 32'hA);

    // 3) all four request from ptr=0, data 1..4, order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) set_din(i, WIDTH'(i + 1));
    req = 4'b1111;
    expect_load("rr0", 0, 4'h1, 1'b1);
    expect_load("rr1", 1, 4'h2, 1'b1);
    expect_load("rr2", 2, 4'h3, 1'b1);
    expect_load("rr3", 3, 4'h4, 1'b1);
    check("rr_req_drained", 32'(gnt), 32'd0);

    // 4) fairness: req[0] and req[3] held -> 0,3,0,3 (ptr wraps 3 -> 0)
    req = 4'b1001;
    expect_load("fair_a", 0, 4'h1, 1'b0);
    expect_load("fair_b", 3, 4'h4, 1'b0);
    expect_load("fair_c", 0, 4'h1, 1'b0);
    expect_load("fair_d", 3, 4'h4, 1'b0);
    req = 4'b0000;
    step();
    check("fair_idle", 32'(busy), 32'd0);

    // 5) abort: req[1] dropped in GRANT; ptr stays 0
    held_dout = dout;
    set_din(1, 4'h7);
    req = 4'b0010;
    step();
    check("abort_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    check("abort_gnt_low", 32'(gnt), 32'd0);
    check("abort_ack",     32'(ack), 32'd0);
    check("abort_busy",    32'(busy), 32'd0);
    check("abort_dout",    32'(dout), 32'(held_dout));
    check("abort_owner",   32'(owner), 32'd3);
    step();
    check("abort_ack_late", 32'(ack), 32'd0);
    // from ptr=0 requester 1 beats requester 3
    req = 4'b1010;
    expect_load("post_abort1", 1, 4'h7, 1'b1);
    expect_load("post_abort3", 3, 4'h4, 1'b1);

    // 6) reset during GRANT; first make ptr=3 so resumption from 0 is visible
    set_din(2, 4'hC);
    req = 4'b0100;
    expect_load("pre_rst", 2, 4'hC, 1'b1);
    req = 4'b0001;
    step();
    check("rst_mid_gnt_pre", 32'(gnt), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_gnt",   32'(gnt), 32'd0);
    check("rstmid_ack",   32'(ack), 32'd0);
    check("rstmid_dout",  32'(dout), 32'd0);
    check("rstmid_valid", 32'(dout_valid), 32'd0);
    check("rstmid_owner", 32'(owner), 32'd0);
    check("rstmid_busy",  32'(busy), 32'd0);
    @(negedge clk);
    step();
    check("rstmid_ack_held", 32'(ack), 32'd0);
    reset = 1'b0;
    req = 4'b1010;
    step();
    check("resume_gnt", 32'(gnt), 32'h2);
    step();
    check("resume_ack",   32'(ack), 32'h2);
    check("resume_dout",  32'(dout), 32'h7);
    req = 4'b0000;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
